// File: rtl/rv32_mem_stage_pkg.sv
// rv32_mem_stage_pkg: shared funct3 codes, stage state encoding and access legality helper
package rv32_mem_stage_pkg;
  localparam int XLEN = 32;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_MEM, S_OUT} state_t;
  function automatic logic f3_ok(input logic [2:0] f, input logic st);
    return st ? (f inside {F3_B, F3_H, F3_W}) : (f inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction
endpackage

// File: rtl/rv32_mem_stage_load_align.sv
// rv32_mem_stage_load_align: picks the addressed byte/half/word out of a read word and extends it
//   rdata  in  32  raw word from data memory
//   funct3 in  3   load width/sign code
//   a      in  2   byte offset inside the word
//   res    out 32  aligned, extended load result
module rv32_mem_stage_load_align
  import rv32_mem_stage_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      a,
  output logic [XLEN-1:0] res
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  assign byte_v = a == 2'd0 ? rdata[7:0] : a == 2'd1 ? rdata[15:8] : a == 2'd2 ? rdata[23:16] : rdata[31:24];
  assign half_v = a[1] ? rdata[31:16] : rdata[15:0];
  assign res = funct3 == F3_W ? rdata
             : funct3[0]      ? {{16{~funct3[2] & half_v[15]}}, half_v}
             :                  {{24{~funct3[2] & byte_v[7]}}, byte_v};
endmodule

// File: rtl/rv32_mem_stage.sv
// rv32_mem_stage: rv32 memory-access stage between execute and writeback
//   EX/MEM in : in_valid/in_ready, in_pc, in_alu_res, in_rs2, in_rd, in_we_rd, in_mem_rd, in_mem_wr, in_funct3
//   dmem      : dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata out; dmem_ack, dmem_rdata in
//   MEM/WB out: out_valid/out_ready, out_pc, out_rd, out_we_rd, out_data, out_err
//   TIMEOUT   : max cycles waiting for dmem_ack, 0 waits forever
//   RV32_MEM_MISALIGN_TRAP_EN: when defined misaligned accesses fault instead of being forced aligned
module rv32_mem_stage
  import rv32_mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_alu_res,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_we_rd,
  input  logic            in_mem_rd,
  input  logic            in_mem_wr,
  input  logic [2:0]      in_funct3,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic            out_we_rd,
  output logic [XLEN-1:0] out_data,
  output logic            out_err
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req_q, req_d, we_q, we_d, we_rd_q, we_rd_d, err_q, err_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d, data_q, data_d;
  logic [3:0]      be_q, be_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      a_q, a_d;
  logic            fire, is_mem, bad, go_mem, half, word, mis;
  logic [1:0]      a, a_eff;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c, ld_res;
  assign in_ready = state_q == S_IDLE || (state_q == S_OUT && out_ready);
  assign fire     = in_valid & in_ready;
  assign a        = in_alu_res[1:0];
  assign half     = in_funct3[1:0] == 2'b01;
  assign word     = in_funct3[1:0] == 2'b10;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
  assign a_eff = a;
  assign mis   = (half & a[0]) | (word & |a);
`else
  // Misaligned offsets are silently rounded down to the natural boundary.
  assign a_eff = word ? 2'b00 : half ? {a[1], 1'b0} : a;
  assign mis   = 1'b0;
`endif
  assign is_mem  = in_mem_rd | in_mem_wr;
  assign bad     = is_mem & ((in_mem_rd & in_mem_wr) | ~f3_ok(in_funct3, in_mem_wr) | mis);
  assign go_mem  = is_mem & ~bad;
  assign be_c    = word ? 4'b1111 : half ? 4'b0011 << {a_eff[1], 1'b0} : 4'b0001 << a_eff;
  assign wdata_c = word ? in_rs2 : half ? {2{in_rs2[15:0]}} : {4{in_rs2[7:0]}};
  rv32_mem_stage_load_align u_align (
    .rdata  (dmem_rdata),
    .funct3 (f3_q),
    .a      (a_q),
    .res    (ld_res)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    we_rd_d = we_rd_q;
    data_d  = data_q;
    err_d   = err_q;
    f3_d    = f3_q;
    a_d     = a_q;
    if (state_q == S_MEM) begin
      cnt_d = cnt_q + 1'b1;
      if (dmem_ack) begin
        state_d = S_OUT;
        req_d   = 1'b0;
        we_d    = 1'b0;
        data_d  = we_q ? '0 : ld_res;
      end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT)) begin
        state_d = S_OUT;
        req_d   = 1'b0;
        we_d    = 1'b0;
        err_d   = 1'b1;
        we_rd_d = 1'b0;
      end
    end else if (fire) begin
      // Counter starts at 1 so it equals the number of MEM cycles spent so far.
      state_d = go_mem ? S_MEM : S_OUT;
      cnt_d   = CW'(1);
      req_d   = go_mem;
      we_d    = go_mem & in_mem_wr;
      addr_d  = {in_alu_res[XLEN-1:2], 2'b00};
      be_d    = be_c;
      wdata_d = wdata_c;
      pc_d    = in_pc;
      rd_d    = in_rd;
      we_rd_d = in_we_rd & ~bad & ~in_mem_wr;
      data_d  = in_alu_res;
      err_d   = bad;
      f3_d    = in_funct3;
      a_d     = a_eff;
    end else if (state_q == S_OUT && out_ready) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      we_rd_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      we_rd_q <= we_rd_d;
      data_q  <= data_d;
      err_q   <= err_d;
      f3_q    <= f3_d;
      a_q     <= a_d;
    end
  end
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign out_valid  = state_q == S_OUT;
  assign out_pc     = pc_q;
  assign out_rd     = rd_q;
  assign out_we_rd  = we_rd_q;
  assign out_data   = data_q;
  assign out_err    = err_q;
endmodule

// File: tb/tb_rv32_mem_stage.sv
// tb_rv32_mem_stage: scoreboard bench for rv32_mem_stage with a queue-driven memory responder
module tb_rv32_mem_stage;
  import rv32_mem_stage_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [31:0] in_pc = '0, in_alu_res = '0, in_rs2 = '0;
  logic [4:0] in_rd = '0;
  logic in_we_rd = 1'b0, in_mem_rd = 1'b0, in_mem_wr = 1'b0;
  logic [2:0] in_funct3 = '0;
  logic dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0] dmem_be;
  logic out_valid, out_ready = 1'b1, out_we_rd, out_err;
  logic [31:0] out_pc, out_data;
  logic [4:0] out_rd;
  logic force_ack = 1'b0;
  int n_cmp = 0, n_bad = 0, last_len = 0;
  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we_rd;
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } exp_t;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        ack;
  } req_t;
  exp_t exp_q[$];
  req_t req_q[$];
  rv32_mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_alu_res(in_alu_res), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_we_rd(in_we_rd), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_funct3(in_funct3),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd), .out_we_rd(out_we_rd),
    .out_data(out_data), .out_err(out_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic push_out(input logic [31:0] pc, input logic [4:0] rd, input logic we_rd, input logic [31:0] data, input logic err, input logic chk_data);
    exp_t e;
    e.pc = pc; e.rd = rd; e.we_rd = we_rd; e.data = data; e.err = err; e.chk_data = chk_data;
    exp_q.push_back(e);
  endtask
  task automatic push_req(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] rdata, input int delay, input logic ack);
    req_t r;
    r.we = we; r.addr = addr; r.be = be; r.wdata = wdata; r.rdata = rdata; r.delay = delay; r.ack = ack;
    req_q.push_back(r);
  endtask
  task automatic send(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd, input logic we_rd, input logic mrd, input logic mwr, input logic [2:0] f3);
    int k = 0;
    in_pc = pc; in_alu_res = alu; in_rs2 = rs2; in_rd = rd; in_we_rd = we_rd;
    in_mem_rd = mrd; in_mem_wr = mwr; in_funct3 = f3; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_accept: got in_ready 0 expected 1 within 100 cycles (pc 0x%08h)", pc);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || dmem_req) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d pending outputs expected 0 within 200 cycles", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask
  // Memory responder: checks each request against the queue and acks after the queued delay.
  initial begin
    req_t cur;
    logic prev = 1'b0;
    int n = 0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    cur.we = 0; cur.addr = 0; cur.be = 0; cur.wdata = 0; cur.rdata = 0; cur.delay = 0; cur.ack = 1;
    forever begin
      @(negedge clk);
      dmem_ack = force_ack;
      if (dmem_req) begin
        if (!prev) begin
          n = 0;
          if (req_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL req_unexpected: got request addr 0x%08h expected none", dmem_addr);
            cur.we = dmem_we; cur.addr = dmem_addr; cur.be = dmem_be; cur.wdata = dmem_wdata;
            cur.rdata = 0; cur.delay = 0; cur.ack = 1;
          end else cur = req_q.pop_front();
        end
        chk1("req_we", dmem_we, cur.we);
        chk("req_addr", dmem_addr, cur.addr);
        if (cur.we) begin
          chk("req_be", 32'(dmem_be), 32'(cur.be));
          chk("req_wdata", dmem_wdata, cur.wdata);
        end
        chk1("req_in_ready", in_ready, 1'b0);
        if (cur.ack && n == cur.delay) begin
          dmem_ack = 1'b1;
          dmem_rdata = cur.rdata;
        end
        n++;
      end else if (prev) last_len = n;
      prev = dmem_req;
    end
  end
  // Output monitor: pops one expectation per completed MEM/WB transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL out_unexpected: got output pc 0x%08h expected none", out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_rd", 32'(out_rd), 32'(e.rd));
          chk1("out_we_rd", out_we_rd, e.we_rd);
          chk1("out_err", out_err, e.err);
          if (e.chk_data) chk("out_data", out_data, e.data);
        end
      end
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk1("reset_req", dmem_req, 1'b0);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, 32'h0);
    chk1("reset_out_err", out_err, 1'b0);
    chk1("reset_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    push_req(0, 32'h104, 4'hF, 0, 32'hDEADBEEF, 3, 1);
    push_out(32'h1000, 5, 1, 32'hDEADBEEF, 0, 1);
    send(32'h1000, 32'h104, 0, 5, 1, 1, 0, F3_W);
    push_req(0, 32'h100, 4'h0, 0, 32'h80112233, 1, 1);
    push_out(32'h1004, 6, 1, 32'hFFFFFF80, 0, 1);
    send(32'h1004, 32'h103, 0, 6, 1, 1, 0, F3_B);
    push_req(0, 32'h100, 4'h0, 0, 32'h80112233, 0, 1);
    push_out(32'h1008, 6, 1, 32'h00000080, 0, 1);
    send(32'h1008, 32'h103, 0, 6, 1, 1, 0, F3_BU);
    push_req(0, 32'h100, 4'h0, 0, 32'h80112233, 2, 1);
    push_out(32'h100C, 7, 1, 32'h00008011, 0, 1);
    send(32'h100C, 32'h102, 0, 7, 1, 1, 0, F3_HU);
    push_req(0, 32'h100, 4'h0, 0, 32'h80112233, 0, 1);
    push_out(32'h1010, 7, 1, 32'hFFFF8011, 0, 1);
    send(32'h1010, 32'h102, 0, 7, 1, 1, 0, F3_H);
    push_req(0, 32'h100, 4'h0, 0, 32'h80112233, 0, 1);
    push_out(32'h1014, 8, 1, 32'h00000033, 0, 1);
    send(32'h1014, 32'h100, 0, 8, 1, 1, 0, F3_B);
    push_req(1, 32'h100, 4'b0010, 32'hABABABAB, 0, 0, 1);
    push_out(32'h1018, 9, 0, 32'h0, 0, 1);
    send(32'h1018, 32'h101, 32'h000000AB, 9, 1, 0, 1, F3_B);
    push_req(1, 32'h100, 4'b1100, 32'hBEEFBEEF, 0, 1, 1);
    push_out(32'h101C, 9, 0, 32'h0, 0, 1);
    send(32'h101C, 32'h102, 32'h0000BEEF, 9, 0, 0, 1, F3_H);
    push_req(1, 32'h208, 4'hF, 32'h12345678, 0, 0, 1);
    push_out(32'h1020, 9, 0, 32'h0, 0, 1);
    send(32'h1020, 32'h208, 32'h12345678, 9, 0, 0, 1, F3_W);
    push_out(32'h1024, 10, 0, 32'h0, 1, 0);
    send(32'h1024, 32'h100, 0, 10, 1, 1, 0, 3'b011);
    push_out(32'h1028, 10, 0, 32'h0, 1, 0);
    send(32'h1028, 32'h100, 32'h55, 10, 0, 0, 1, F3_BU);
    push_out(32'h102C, 10, 0, 32'h0, 1, 0);
    send(32'h102C, 32'h100, 0, 10, 1, 1, 1, F3_W);
`ifdef RV32_MEM_MISALIGN_TRAP_EN
    push_out(32'h1030, 11, 0, 32'h0, 1, 0);
    send(32'h1030, 32'h101, 32'h1234, 11, 0, 0, 1, F3_H);
    push_out(32'h1034, 11, 0, 32'h0, 1, 0);
    send(32'h1034, 32'h106, 0, 11, 1, 1, 0, F3_W);
    push_out(32'h1038, 11, 0, 32'h0, 1, 0);
    send(32'h1038, 32'h103, 0, 11, 1, 1, 0, F3_H);
`else
    push_req(1, 32'h100, 4'b0011, 32'h12341234, 0, 0, 1);
    push_out(32'h1030, 11, 0, 32'h0, 0, 1);
    send(32'h1030, 32'h101, 32'h1234, 11, 0, 0, 1, F3_H);
    push_req(0, 32'h104, 4'h0, 0, 32'hCAFEF00D, 0, 1);
    push_out(32'h1034, 11, 1, 32'hCAFEF00D, 0, 1);
    send(32'h1034, 32'h106, 0, 11, 1, 1, 0, F3_W);
    push_req(0, 32'h100, 4'h0, 0, 32'h80112233, 0, 1);
    push_out(32'h1038, 11, 1, 32'hFFFF8011, 0, 1);
    send(32'h1038, 32'h103, 0, 11, 1, 1, 0, F3_H);
`endif
    drain();
    out_ready = 1'b0;
    push_out(32'h2000, 2, 1, 32'h5, 0, 1);
    send(32'h2000, 32'h5, 0, 2, 1, 0, 0, 3'b000);
    repeat (4) begin
      @(negedge clk);
      chk1("stall_out_valid", out_valid, 1'b1);
      chk("stall_out_data", out_data, 32'h5);
      chk("stall_out_pc", out_pc, 32'h2000);
      chk1("stall_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    push_out(32'h2004, 3, 1, 32'h77, 0, 1);
    send(32'h2004, 32'h77, 0, 3, 1, 0, 0, 3'b000);
    drain();
    push_req(0, 32'h300, 4'h0, 0, 0, 0, 0);
    push_out(32'h3000, 12, 0, 32'h0, 1, 0);
    send(32'h3000, 32'h300, 0, 12, 1, 1, 0, F3_W);
    drain();
    chk("timeout_req_cycles", last_len, 32'd4);
    push_req(0, 32'h400, 4'h0, 0, 0, 0, 0);
    send(32'h4000, 32'h400, 0, 13, 1, 1, 0, F3_W);
    @(negedge clk);
    chk1("mem_req_before_reset", dmem_req, 1'b1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    chk1("rst_mem_req_dropped", dmem_req, 1'b0);
    chk1("rst_mem_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1 force_ack = 1'b0;
    @(negedge clk);
    chk1("stray_ack_out_valid", out_valid, 1'b0);
    chk1("stray_ack_req", dmem_req, 1'b0);
    chk1("stray_ack_in_ready", in_ready, 1'b1);
    chk("stray_ack_out_data", out_data, 32'h0);
    @(posedge clk);
    #1;
    push_out(32'h5000, 1, 1, 32'h99, 0, 1);
    send(32'h5000, 32'h99, 0, 1, 1, 0, 0, 3'b000);
    drain();
    chk("exp_left", exp_q.size(), 32'd0);
    chk("req_left", req_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
